neopixel_driver: RTL and testbench

NEOPIXEL_DRIVER -- requirements
Module: neopixel_driver

---
 rtl/neo_pkg.sv | 34 +++
 rtl/neopixel_driver_if.sv | 30 +++
 rtl/neo_bit_timer.sv | 52 +++++
 rtl/neopixel_driver.sv | 140 ++++++++++++++
 tb/tb_neopixel_driver.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neo_pkg.sv
// Shared state/colour types, default WS2812 timing and counter widths
// used by the neopixel driver and its bit timer.
package neo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } neo_state_t;

  typedef enum logic [1:0] {
    GREEN = 2'd0,
    RED   = 2'd1,
    BLUE  = 2'd2
  } color_t;

  localparam int DEF_NUM_PIXELS = 5;
  localparam int DEF_T0H        = 20;
  localparam int DEF_T1H        = 40;
  localparam int DEF_TBIT       = 63;
  localparam int DEF_TLATCH     = 2500;

  localparam int BITS_PER_COLOR = 8;
  localparam int BITS_PER_PIXEL = 24;

  localparam int BIT_TIMER_W = 6;
  localparam int BIT_INDEX_W = 7;
  localparam int LATCH_CNT_W = 12;

  function automatic logic color_valid(input logic [1:0] ci);
    return (ci == GREEN) || (ci == RED) || (ci == BLUE);
  endfunction

endpackage

// File: rtl/neopixel_driver_if.sv
// Host-side load/send handshake and status bundle of the neopixel driver,
// including the serial data line.
interface neopixel_driver_if;

  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;

  logic       ready_to_load;
  logic       ready_to_send;
  logic       begin_send;
  logic       done_send;
  logic       done_wait;
  logic       neo_data;

  modport master (
    output load_color, pixel_index, color_index, color_level, send_it,
    input  ready_to_load, ready_to_send, begin_send, done_send, done_wait,
           neo_data
  );

  modport slave (
    input  load_color, pixel_index, color_index, color_level, send_it,
    output ready_to_load, ready_to_send, begin_send, done_send, done_wait,
           neo_data
  );

endinterface

// File: rtl/neo_bit_timer.sv
// Shapes one WS2812 bit period: high for T1H (1) or T0H (0) cycles, then
// low until TBIT cycles have elapsed. start_i is held for the whole frame.
module neo_bit_timer
  import neo_pkg::*;
#(
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H,
  parameter int TBIT = DEF_TBIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start_i,
  input  logic bit_i,
  output logic neo_data_o,
  output logic bit_done_o
);

  localparam logic [BIT_TIMER_W-1:0] T0H_W     = BIT_TIMER_W'(T0H);
  localparam logic [BIT_TIMER_W-1:0] T1H_W     = BIT_TIMER_W'(T1H);
  localparam logic [BIT_TIMER_W-1:0] TBIT_LAST = BIT_TIMER_W'(TBIT - 1);

  logic [BIT_TIMER_W-1:0] cnt_q, cnt_d;
  logic [BIT_TIMER_W-1:0] highLen;
  logic                   periodEnd;

  assign highLen   = bit_i ? T1H_W : T0H_W;
  assign periodEnd = (cnt_q == TBIT_LAST);

  // The counter idles at zero so the first cycle of a frame starts high.
  always_comb begin
    cnt_d = cnt_q;
    if (!start_i) begin
      cnt_d = '0;
    end else if (periodEnd) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + BIT_TIMER_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign neo_data_o = start_i && (cnt_q < highLen);
  assign bit_done_o = start_i && periodEnd;

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 chain driver: stores GRB bytes for each pixel and, on request,
// streams one frame (pixel 0 first, MSB first) followed by a latch gap.
module neopixel_driver
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int T0H        = DEF_T0H,
  parameter int T1H        = DEF_T1H,
  parameter int TBIT       = DEF_TBIT,
  parameter int TLATCH     = DEF_TLATCH
) (
  input  logic              clock,
  input  logic              reset_n,
  neopixel_driver_if.slave  bus
);

  localparam int FRAME_BITS = NUM_PIXELS * BITS_PER_PIXEL;

  localparam logic [BIT_INDEX_W-1:0] LAST_BIT    = BIT_INDEX_W'(FRAME_BITS - 1);
  localparam logic [LATCH_CNT_W-1:0] LATCH_LAST  = LATCH_CNT_W'(TLATCH - 1);
  localparam logic [3:0]             PIXEL_LIMIT = 4'(NUM_PIXELS);

  neo_state_t state_q, state_d;

  logic [BIT_INDEX_W-1:0] bitIdx_q, bitIdx_d;
  logic [LATCH_CNT_W-1:0] latchCnt_q, latchCnt_d;
  logic [FRAME_BITS-1:0]  colors_q, colors_d;

  logic                   writeEn;
  logic [BIT_INDEX_W-1:0] wrOfs;
  logic [BIT_INDEX_W-1:0] wrBase;
  logic [BIT_INDEX_W-1:0] rdSel;
  logic                   curBit;
  logic                   timerRun;
  logic                   timerData;
  logic                   bitDone;
  logic                   beginSend;
  logic                   doneSend;
  logic                   doneWait;

  // Storage is one flat vector laid out in transmit order: frame bit k
  // lives at colors_q[FRAME_BITS-1-k], so both writes and reads are simple
  // offsets from the top.
  assign wrOfs  = BIT_INDEX_W'(bus.pixel_index) * BIT_INDEX_W'(BITS_PER_PIXEL)
                + BIT_INDEX_W'(bus.color_index) * BIT_INDEX_W'(BITS_PER_COLOR);
  assign wrBase = LAST_BIT - wrOfs;
  assign rdSel  = LAST_BIT - bitIdx_q;
  assign curBit = colors_q[rdSel];

  assign writeEn = (state_q == IDLE) && bus.load_color
                && ({1'b0, bus.pixel_index} < PIXEL_LIMIT)
                && color_valid(bus.color_index);

  assign timerRun = (state_q == SEND);

  neo_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_bit_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .start_i    (timerRun),
    .bit_i      (curBit),
    .neo_data_o (timerData),
    .bit_done_o (bitDone)
  );

  // A write and a send in the same IDLE cycle both take effect, so the
  // new byte is already in storage when the first bit is read.
  always_comb begin
    state_d    = state_q;
    bitIdx_d   = bitIdx_q;
    latchCnt_d = latchCnt_q;
    colors_d   = colors_q;
    beginSend  = 1'b0;
    doneSend   = 1'b0;
    doneWait   = 1'b0;

    if (writeEn) begin
      colors_d[wrBase -: 8] = bus.color_level;
    end

    case (state_q)
      IDLE: begin
        if (bus.send_it) begin
          state_d   = SEND;
          bitIdx_d  = '0;
          beginSend = 1'b1;
        end
      end
      SEND: begin
        if (bitDone) begin
          if (bitIdx_q == LAST_BIT) begin
            bitIdx_d   = '0;
            latchCnt_d = '0;
            doneSend   = 1'b1;
            state_d    = LATCH;
          end else begin
            bitIdx_d = bitIdx_q + BIT_INDEX_W'(1);
          end
        end
      end
      LATCH: begin
        if (latchCnt_q == LATCH_LAST) begin
          latchCnt_d = '0;
          doneWait   = 1'b1;
          state_d    = IDLE;
        end else begin
          latchCnt_d = latchCnt_q + LATCH_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitIdx_q   <= '0;
      latchCnt_q <= '0;
      colors_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitIdx_q   <= bitIdx_d;
      latchCnt_q <= latchCnt_d;
      colors_q   <= colors_d;
    end
  end

  assign bus.ready_to_load = (state_q == IDLE);
  assign bus.ready_to_send = (state_q == IDLE);
  assign bus.begin_send    = beginSend;
  assign bus.done_send     = doneSend;
  assign bus.done_wait     = doneWait;
  assign bus.neo_data      = timerData;

endmodule

// File: tb/tb_neopixel_driver.sv
// Scoreboard bench for neopixel_driver: stimulus pushes expected frame bits
// from a byte-array model; a negedge monitor decodes neo_data and compares.
`timescale 1ns/1ps
module tb_neopixel_driver;
  import neo_pkg::*;

  localparam int NUM_PIXELS   = 5;
  localparam int T0H          = 20;
  localparam int T1H          = 40;
  localparam int TBIT         = 63;
  localparam int TLATCH       = 2500;
  localparam int FRAME_BITS   = NUM_PIXELS * 24;
  localparam int FRAME_BUDGET = FRAME_BITS * TBIT + TLATCH + 1000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  neopixel_driver_if bus ();

  neopixel_driver #(
    .NUM_PIXELS (NUM_PIXELS),
    .T0H        (T0H),
    .T1H        (T1H),
    .TBIT       (TBIT),
    .TLATCH     (TLATCH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] model [NUM_PIXELS][3];
  bit         expBits [$];

  int framesStarted = 0;
  int framesDone    = 0;

  bit inFrame = 0, inLatch = 0, checkIdleNext = 0;
  int bitCnt = 0, cycInBit = 0, highCnt = 0, latchCyc = 0;
  bit sawLow = 0, shapeBad = 0, readyBad = 0, strayBad = 0, latchBad = 0;
  bit idleBad = 0, resetBad = 0;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clearModel();
    for (int p = 0; p < NUM_PIXELS; p++)
      for (int c = 0; c < 3; c++)
        model[p][c] = 8'h00;
  endtask

  // Transmission order: pixel 0 first, then G, R, B, each MSB first.
  task automatic pushFrame();
    for (int p = 0; p < NUM_PIXELS; p++)
      for (int c = 0; c < 3; c++)
        for (int b = 7; b >= 0; b--)
          expBits.push_back(model[p][c][b]);
  endtask

  task automatic applyStimulus(input bit load, input int pix, input int col,
                               input int lvl, input bit send, input bit inIdle);
    @(posedge clock);
    #1;
    bus.load_color  = load;
    bus.pixel_index = 3'(pix);
    bus.color_index = 2'(col);
    bus.color_level = 8'(lvl);
    bus.send_it     = send;
    if (inIdle && load && pix < NUM_PIXELS && col < 3)
      model[pix][col] = 8'(lvl);
    if (inIdle && send)
      pushFrame();
    @(posedge clock);
    #1;
    bus.load_color = 1'b0;
    bus.send_it    = 1'b0;
  endtask

  task automatic waitFrameDone();
    int start = framesDone;
    int n = 0;
    while (framesDone == start && n < FRAME_BUDGET) begin
      @(posedge clock);
      n++;
    end
    checkOutput("frame_complete", framesDone - start, 1);
    repeat (2) @(posedge clock);
  endtask

  initial begin : monitor
    bit lastCyc;
    bit expBit;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        if (inFrame || inLatch) begin
          checkOutput("abort_no_done_send", int'(strayBad), 0);
          expBits.delete();
        end
        inFrame = 0; inLatch = 0; checkIdleNext = 0;
        shapeBad = 0; readyBad = 0; strayBad = 0; latchBad = 0;
        if (bus.neo_data || bus.done_send || bus.done_wait || bus.begin_send)
          resetBad = 1;
      end else if (inFrame) begin
        if (bus.ready_to_load || bus.ready_to_send) readyBad = 1;
        if (bus.begin_send || bus.done_wait) strayBad = 1;
        if (bus.neo_data) begin
          if (sawLow) shapeBad = 1;
          highCnt++;
        end else begin
          sawLow = 1;
        end
        lastCyc = (cycInBit == TBIT - 1);
        if (bus.done_send && !(lastCyc && bitCnt == FRAME_BITS - 1)) strayBad = 1;
        if (lastCyc) begin
          if (expBits.size() == 0) begin
            checkOutput("unexpected_frame_bit", 1, 0);
          end else begin
            expBit = expBits.pop_front();
            checkOutput($sformatf("bit%0d_high_cycles", bitCnt), highCnt,
                        expBit ? T1H : T0H);
          end
          highCnt = 0; sawLow = 0; cycInBit = 0;
          if (bitCnt == FRAME_BITS - 1) begin
            checkOutput("done_send_on_last_cycle", int'(bus.done_send), 1);
            inFrame = 0; inLatch = 1; latchCyc = 0; bitCnt = 0;
          end else begin
            bitCnt++;
          end
        end else begin
          cycInBit++;
        end
      end else if (inLatch) begin
        if (bus.neo_data) latchBad = 1;
        if (bus.ready_to_load || bus.ready_to_send) readyBad = 1;
        if (bus.begin_send || bus.done_send) strayBad = 1;
        latchCyc++;
        if (latchCyc == TLATCH) begin
          checkOutput("done_wait_on_last_cycle", int'(bus.done_wait), 1);
          checkOutput("frame_bit_shape", int'(shapeBad), 0);
          checkOutput("frame_not_ready", int'(readyBad), 0);
          checkOutput("frame_no_stray_pulse", int'(strayBad), 0);
          checkOutput("latch_data_low", int'(latchBad), 0);
          shapeBad = 0; readyBad = 0; strayBad = 0; latchBad = 0;
          inLatch = 0; checkIdleNext = 1;
          framesDone++;
        end else if (bus.done_wait) begin
          strayBad = 1;
        end
      end else begin
        if (checkIdleNext) begin
          checkOutput("ready_after_latch",
                      int'({bus.ready_to_load, bus.ready_to_send}), 3);
          checkIdleNext = 0;
        end
        if (bus.neo_data || bus.done_send || bus.done_wait) idleBad = 1;
        if (bus.begin_send) begin
          if (!bus.send_it) idleBad = 1;
          inFrame = 1; framesStarted++;
          bitCnt = 0; cycInBit = 0; highCnt = 0; sawLow = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int fs;
    int n;
    bus.load_color  = 1'b0;
    bus.pixel_index = 3'd0;
    bus.color_index = 2'd0;
    bus.color_level = 8'd0;
    bus.send_it     = 1'b0;
    clearModel();

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("reset_ready_to_load", int'(bus.ready_to_load), 1);
    checkOutput("reset_ready_to_send", int'(bus.ready_to_send), 1);
    checkOutput("reset_neo_data", int'(bus.neo_data), 0);

    $display("[TB] frame with empty storage");
    applyStimulus(0, 0, 0, 0, 1, 1);
    waitFrameDone();

    $display("[TB] pixel 0 green = 0x80");
    applyStimulus(1, 0, GREEN, 8'h80, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    waitFrameDone();

    $display("[TB] pixel 4 blue = 0x01 with invalid writes");
    applyStimulus(1, 0, GREEN, 8'h00, 0, 1);
    applyStimulus(1, 4, BLUE, 8'h01, 0, 1);
    applyStimulus(1, 5, GREEN, 8'hAA, 0, 1);
    applyStimulus(1, 1, 3, 8'h55, 0, 1);
    applyStimulus(1, 7, 3, 8'hFF, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    waitFrameDone();

    $display("[TB] random loads, then loads and send during the frame");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 255), 0, 1);
    applyStimulus(1, 2, RED, $urandom_range(0, 254), 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    repeat (100) @(posedge clock);
    applyStimulus(1, 2, RED, 8'hFF, 0, 0);
    n = 0;
    while (!inLatch && n < FRAME_BUDGET) begin
      @(posedge clock);
      n++;
    end
    checkOutput("reach_latch", int'(inLatch), 1);
    applyStimulus(1, 2, RED, 8'hFF, 1, 0);
    waitFrameDone();
    fs = framesStarted;
    repeat (50) @(posedge clock);
    checkOutput("no_queued_send", framesStarted - fs, 0);

    $display("[TB] second frame keeps pixel 2 red");
    applyStimulus(0, 0, 0, 0, 1, 1);
    waitFrameDone();

    $display("[TB] reset during bit 60");
    applyStimulus(0, 0, 0, 0, 1, 1);
    n = 0;
    while (!(inFrame && bitCnt == 60 && cycInBit == 5) && n < FRAME_BUDGET) begin
      @(posedge clock);
      n++;
    end
    checkOutput("reach_bit60", int'(inFrame && bitCnt == 60), 1);
    #2;
    checkOutput("bit60_high_before_reset", int'(bus.neo_data), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_async_neo_data", int'(bus.neo_data), 0);
    checkOutput("reset_async_ready", int'(bus.ready_to_load), 1);
    clearModel();
    repeat (4) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    #1;
    checkOutput("release_ready_to_load", int'(bus.ready_to_load), 1);
    checkOutput("release_ready_to_send", int'(bus.ready_to_send), 1);

    $display("[TB] storage cleared, random load together with send");
    applyStimulus(1, $urandom_range(0, 4), $urandom_range(0, 2),
                  $urandom_range(1, 255), 0, 1);
    applyStimulus(1, $urandom_range(0, 4), $urandom_range(0, 2),
                  $urandom_range(1, 255), 1, 1);
    waitFrameDone();

    repeat (10) @(posedge clock);
    checkOutput("scoreboard_empty", expBits.size(), 0);
    checkOutput("reset_outputs_low", int'(resetBad), 0);
    checkOutput("idle_outputs_quiet", int'(idleBad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
